sr_latch_monitor: RTL and testbench

SR_LATCH_MONITOR -- requirements
Module: sr_latch_monitor

---
 rtl/sr_latch_monitor.sv | 175 +++++++++++++++++
 tb/tb_sr_latch_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_monitor.sv
// Latch settle monitor: counts Q edges, longest Q-high run and Q==NQ cycles; optional MON_GLITCH_FILTER_EN drops 1-cycle pulses.
// Results held on res_valid until res_ready; res_valid rises SETTLE_CYCLES+3 cycles after the last Q change (+2 with the filter).
module sr_latch_monitor #(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 150
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             q_in,
  input  logic             nq_in,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_final,
  output logic [7:0]       res_edges,
  output logic [CNT_W-1:0] res_qhigh_max,
  output logic [CNT_W-1:0] res_invalid,
  output logic             res_timeout
);

  localparam int QW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [QW-1:0]    QUIET_DONE = QW'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {IDLE, WAIT_ACT, OBSERVE, REPORT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_q_s1, r_q_s2, r_nq_s1, r_nq_s2;
  logic             w_qs, w_nqs;
  logic             r_q_prev;
  logic [QW-1:0]    r_quiet;
  logic [QW-1:0]    w_quiet_inc;
  logic [CNT_W-1:0] r_run;
  logic [CNT_W-1:0] w_run_nxt;
  logic [7:0]       r_edges;
  logic [CNT_W-1:0] r_qhigh_max;
  logic [CNT_W-1:0] r_invalid;
  logic             r_final;
  logic             r_timeout;
  logic             w_q_edge, w_q_fall, w_measure;
  logic             w_clear, w_obs_done, w_timeout_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_s1  <= 1'b0;
      r_q_s2  <= 1'b0;
      r_nq_s1 <= 1'b0;
      r_nq_s2 <= 1'b0;
    end else begin
      r_q_s1  <= q_in;
      r_q_s2  <= r_q_s1;
      r_nq_s1 <= nq_in;
      r_nq_s2 <= r_nq_s1;
    end
  end

`ifdef MON_GLITCH_FILTER_EN
  // A level is accepted once it has been seen on two consecutive cycles.
  logic r_q_d, r_nq_d, r_q_f, r_nq_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_d  <= 1'b0;
      r_nq_d <= 1'b0;
      r_q_f  <= 1'b0;
      r_nq_f <= 1'b0;
    end else begin
      r_q_d  <= r_q_s2;
      r_nq_d <= r_nq_s2;
      if (r_q_s2 == r_q_d) r_q_f <= r_q_s2;
      if (r_nq_s2 == r_nq_d) r_nq_f <= r_nq_s2;
    end
  end

  assign w_qs  = r_q_f;
  assign w_nqs = r_nq_f;
`else
  assign w_qs  = r_q_s2;
  assign w_nqs = r_nq_s2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q_prev <= 1'b0;
    else     r_q_prev <= w_qs;
  end

  assign w_q_edge    = w_qs ^ r_q_prev;
  assign w_q_fall    = r_q_prev & ~w_qs;
  assign w_measure   = (r_state == WAIT_ACT) || (r_state == OBSERVE);
  assign w_quiet_inc = (r_quiet == QUIET_DONE) ? r_quiet : r_quiet + 1'b1;
  assign w_run_nxt   = (w_qs && r_run != CNT_MAX) ? r_run + 1'b1 : r_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clear       = 1'b0;
    w_obs_done    = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (arm) begin
          w_state_nxt = WAIT_ACT;
          w_clear     = 1'b1;
        end
      end
      WAIT_ACT: begin
        if (w_q_edge) begin
          w_state_nxt = OBSERVE;
        end else if (w_quiet_inc == QUIET_DONE) begin
          w_state_nxt   = REPORT;
          w_timeout_set = 1'b1;
        end
      end
      OBSERVE: begin
        if (!w_q_edge && w_quiet_inc == QUIET_DONE) begin
          w_state_nxt = REPORT;
          w_obs_done  = 1'b1;
        end
      end
      REPORT: begin
        if (res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quiet     <= '0;
      r_run       <= '0;
      r_edges     <= '0;
      r_qhigh_max <= '0;
      r_invalid   <= '0;
      r_final     <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (w_clear) begin
      r_quiet     <= '0;
      r_run       <= '0;
      r_edges     <= '0;
      r_qhigh_max <= '0;
      r_invalid   <= '0;
      r_final     <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (w_measure) begin
      if (w_q_edge) begin
        if (r_edges != 8'hFF) r_edges <= r_edges + 1'b1;
        r_quiet <= '0;
      end else begin
        r_quiet <= w_quiet_inc;
      end
      if (w_qs == w_nqs && r_invalid != CNT_MAX) r_invalid <= r_invalid + 1'b1;
      // A run closes on Q falling or when the measurement ends with Q still high.
      if ((w_q_fall || w_obs_done) && w_run_nxt > r_qhigh_max) r_qhigh_max <= w_run_nxt;
      if (w_q_fall) r_run <= '0;
      else          r_run <= w_run_nxt;
      if (w_obs_done)    r_final   <= w_qs;
      if (w_timeout_set) r_timeout <= 1'b1;
    end
  end

  assign busy          = (r_state != IDLE);
  assign res_valid     = (r_state == REPORT);
  assign res_final     = r_final;
  assign res_edges     = r_edges;
  assign res_qhigh_max = r_qhigh_max;
  assign res_invalid   = r_invalid;
  assign res_timeout   = r_timeout;

endmodule

// File: tb/tb_sr_latch_monitor.sv
// Bench for sr_latch_monitor: expected results queued per measurement, compared at the result handshake.
// Honours MON_GLITCH_FILTER_EN for the extra latency and glitch-drop expectations.
module tb_sr_latch_monitor;

  localparam int CNT_W = 16;
  localparam int S     = 150;
`ifdef MON_GLITCH_FILTER_EN
  localparam int LAT_EXTRA = 2;
`else
  localparam int LAT_EXTRA = 0;
`endif
  localparam int LAT = S + 3 + LAT_EXTRA;

  logic             clk = 1'b0;
  logic             rst, arm, q_in, nq_in, res_ready;
  logic             busy, res_valid, res_final, res_timeout;
  logic [7:0]       res_edges;
  logic [CNT_W-1:0] res_qhigh_max, res_invalid;

  typedef struct {
    logic fin;
    int   edges;
    int   qhigh;
    int   invalid;
    logic timeout;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t last_exp;
  int   n_checks = 0;
  int   n_errors = 0;

  sr_latch_monitor #(.CNT_W(CNT_W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .arm(arm), .q_in(q_in), .nq_in(nq_in),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_final(res_final), .res_edges(res_edges), .res_qhigh_max(res_qhigh_max),
    .res_invalid(res_invalid), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop and compare when the DUT hands a result over.
  always @(negedge clk) begin
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk_val("res_final", {31'd0, res_final}, {31'd0, mon_e.fin});
        chk_val("res_edges", {24'd0, res_edges}, mon_e.edges);
        if (mon_e.qhigh >= 0) chk_val("res_qhigh_max", {16'd0, res_qhigh_max}, mon_e.qhigh);
        chk_val("res_invalid", {16'd0, res_invalid}, mon_e.invalid);
        chk_val("res_timeout", {31'd0, res_timeout}, {31'd0, mon_e.timeout});
        last_exp = mon_e;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic finish_result(input string tag, input int exp_lat);
    int cyc;
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < S + 400) begin
      @(negedge clk);
      cyc++;
    end
    if (res_valid !== 1'b1) begin
      chk_val({tag, "_no_valid"}, 32'd0, 32'd1);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(4);
      sb_q.delete();
      return;
    end
    if (exp_lat >= 0) chk_val({tag, "_latency"}, cyc, exp_lat);
    tick(1);
    chk_val({tag, "_hold1"}, {31'd0, res_valid}, 32'd1);
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(2);
    chk_val({tag, "_hold2"}, {31'd0, res_valid}, 32'd1);
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    chk_val({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk_val({tag, "_idle_valid"}, {31'd0, res_valid}, 32'd0);
    tick(4);
    chk_val({tag, "_keep_edges"}, {24'd0, res_edges}, last_exp.edges);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, observed hang, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arm = 1'b0; q_in = 1'b0; nq_in = 1'b1; res_ready = 1'b0;
    #1;
    chk_val("rst_busy", {31'd0, busy}, 32'd0);
    chk_val("rst_valid", {31'd0, res_valid}, 32'd0);
    chk_val("rst_edges", {24'd0, res_edges}, 32'd0);
    chk_val("rst_invalid", {16'd0, res_invalid}, 32'd0);
    chk_val("rst_qhigh", {16'd0, res_qhigh_max}, 32'd0);
    chk_val("rst_final_to", {30'd0, res_final, res_timeout}, 32'd0);
    tick(3);
    rst = 1'b0;
    tick(5);

    // Single clean rise held high.
    do_arm();
    q_in = 1'b1; nq_in = 1'b0;
    sb_q.push_back('{fin: 1'b1, edges: 1, qhigh: S + 1, invalid: 0, timeout: 1'b0});
    finish_result("rise", LAT);

    // No activity: timeout.
    do_arm();
    sb_q.push_back('{fin: 1'b0, edges: 0, qhigh: -1, invalid: 0, timeout: 1'b1});
    finish_result("timeout", S);

    // Starting high, five toggles then high again; stray arm mid-measurement.
    do_arm();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        tick(9);
      end else begin
        tick(10);
      end
      q_in = ~q_in; nq_in = ~nq_in;
    end
    sb_q.push_back('{fin: 1'b1, edges: 6, qhigh: S + 1, invalid: 0, timeout: 1'b0});
    finish_result("toggle", LAT);

    // Q and NQ both high for 20 cycles.
    q_in = 1'b0; nq_in = 1'b1;
    tick(6);
    do_arm();
    q_in = 1'b1;
    tick(20);
    nq_in = 1'b0;
    sb_q.push_back('{fin: 1'b1, edges: 1, qhigh: S + 1, invalid: 20, timeout: 1'b0});
    finish_result("invalid", -1);

    // One-cycle glitch on Q.
    q_in = 1'b0; nq_in = 1'b1;
    tick(6);
    do_arm();
    tick(5);
    q_in = 1'b1;
    tick(1);
    q_in = 1'b0;
`ifdef MON_GLITCH_FILTER_EN
    sb_q.push_back('{fin: 1'b0, edges: 0, qhigh: -1, invalid: 0, timeout: 1'b1});
    finish_result("glitch", -1);
`else
    sb_q.push_back('{fin: 1'b0, edges: 2, qhigh: 1, invalid: 1, timeout: 1'b0});
    finish_result("glitch", LAT);
`endif

    // Edge counter saturation: 260 transitions at 4-cycle spacing.
    tick(4);
    do_arm();
    for (int i = 0; i < 260; i++) begin
      tick(4);
      q_in = ~q_in; nq_in = ~nq_in;
    end
    sb_q.push_back('{fin: 1'b0, edges: 255, qhigh: 4, invalid: 0, timeout: 1'b0});
    finish_result("saturate", LAT);

    // Reset in OBSERVE aborts; a fresh measurement afterwards is clean.
    do_arm();
    q_in = 1'b1; nq_in = 1'b0;
    tick(30);
    chk_val("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk_val("abort_busy", {31'd0, busy}, 32'd0);
    chk_val("abort_valid", {31'd0, res_valid}, 32'd0);
    chk_val("abort_edges", {24'd0, res_edges}, 32'd0);
    tick(2);
    rst = 1'b0;
    q_in = 1'b0; nq_in = 1'b1;
    tick(6);
    chk_val("post_abort_valid", {31'd0, res_valid}, 32'd0);
    do_arm();
    q_in = 1'b1; nq_in = 1'b0;
    sb_q.push_back('{fin: 1'b1, edges: 1, qhigh: S + 1, invalid: 0, timeout: 1'b0});
    finish_result("rearm", LAT);

    chk_val("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
